video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Parametrised successor to the fixed-mode HDMI PMOD timing interface: generates DE/HS/VS, pixel coordinates and RGB for a DVI/HDMI transmitter.
- Adds configurable colour width, runtime-reprogrammable timing applied glitch-free at frame boundaries, a pixel-fetch latency pipeline for RAM-backed framebuffers, and line/frame strobes.
- Sits between the framebuffer/pattern source and the HDMI PMOD pins.

Parameters:
- RGB_WIDTH, 3, bits per pixel on pixel_data and rgb.
- COORD_WIDTH, 11, width of x/y.
- PIXEL_LATENCY, 1, cycles from x/y valid to matching pixel_data; range 0..7.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 800/56/120/64, reset horizontal timing.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 600/37/6/23, reset vertical timing.
- H_POL/V_POL, 1/1, active sync level.

Ports:
- clk_in  in  1  pixel clock; sole clock.
- rst_in  in  1  synchronous, active-high reset.
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  12 each  new horizontal timing.
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  12 each  new vertical timing.
- cfg_valid  in  1  one-cycle strobe; captures all cfg_* fields.
- cfg_pending  out  1  captured config not yet applied.
- clk_out  out  1  equals clk_in.
- x, y  out  COORD_WIDTH  fetch-side coordinates; 0 outside active area.
- fetch  out  1  fetch-side DE; x/y valid.
- pixel_data  in  RGB_WIDTH  pixel for x/y, PIXEL_LATENCY cycles after fetch.
- line_start, frame_start  out  1  fetch-side strobes.
- de, hs, vs  out  1  aligned video controls.
- rgb  out  RGB_WIDTH  pixel, 0 when de=0.
- tp_sel  in  1  test-pattern select; used only with VTG_TEST_PATTERN_EN.

Behaviour:
- Line order per axis: front porch, sync, back porch, active. H_TOTAL = fp+sync+bp+active, likewise V_TOTAL. Counters hc, vc are 12-bit and start at 0.
- hc increments every cycle. At hc==H_TOTAL-1, hc wraps to 0 and vc increments. At vc==V_TOTAL-1, vc wraps to 0.
- fetch = (hc >= fp+sync+bp) && (vc >= vfp+vsync+vbp). x = hc-(fp+sync+bp) and y = vc-(...) when fetch; else 0. Results are truncated to COORD_WIDTH.
- line_start = (hc==0). frame_start = (hc==0 && vc==0). Both are combinational from the counters.
- Output pipeline: de/hs/vs are the fetch-side values delayed by PIXEL_LATENCY+1 register stages.
- rgb register captures pixel_data when the delayed-by-PIXEL_LATENCY de is 1, else 0. Net effect: de, hs, vs and rgb are coincident, and rgb is the pixel for the x/y issued PIXEL_LATENCY+1 cycles earlier.
- hs = H_POL while fp <= hc < fp+sync, else ~H_POL. vs is the same on vc with V_POL.
- Config: cfg_valid captures all cfg_* fields into a pending set and sets cfg_pending.
  - Pending is applied to the active set on the cycle the counters wrap at frame end (hc==H_TOTAL-1 && vc==V_TOTAL-1). cfg_pending clears on that cycle.
  - If cfg_valid coincides with the wrap cycle, the new set is captured but applied at the next frame end; cfg_pending stays 1.
  - A repeated cfg_valid while pending overwrites the pending set (last wins).
- Degenerate config: sync=0 gives no pulse; active=0 gives fetch/de never asserted. A total <2 is unsupported and must not be loaded.
- Reset (rst_in=1 at clk edge), all regardless of in-flight state:
  - hc=vc=0; active and pending sets loaded from parameters; cfg_pending=0.
  - Pipeline cleared: de=0, hs=~H_POL, vs=~V_POL, rgb=0.
  - Reset mid-line or mid-frame restarts the timing at frame_start on the first cycle after reset deasserts.

Optional Feature:
- VTG_TEST_PATTERN_EN defined: when tp_sel=1, the rgb source is replaced by eight vertical colour bars. Bar index = x*8/H_ACTIVE of the delayed coordinate; the bar value is the index replicated/truncated to RGB_WIDTH. pixel_data is ignored, and latency and alignment are unchanged.
- Undefined: no pattern logic; tp_sel is ignored; rgb always comes from pixel_data.

Test Plan:
- Reset defaults, PIXEL_LATENCY=1: first de=1 at hc=240, vc=66 plus 2 cycles. Measured HS low→high at hc=56, width 120; VS width 6 lines; frame period 1040*666=692640 clocks.
- Latency alignment: pixel_data = x[2:0] delayed by PIXEL_LATENCY, for PIXEL_LATENCY=0,1,3 → rgb = 0,1,2… aligned to the first de cycle of each line; no off-by-one.
- Reconfig: pulse cfg_valid mid-frame with 640/16/96/48, 480/10/2/33 → current frame keeps 1040-clock lines; next frame has 800-clock lines and 525 lines; cfg_pending 1→0 exactly at the wrap.
- Simultaneous cfg_valid on the wrap cycle → applied one frame later; a second cfg_valid while pending → only the second set takes effect.
- Reset asserted mid-active-line → next cycle de=0, hs=vs inactive, rgb=0; frame_start=1 on the first cycle after release.
- VTG_TEST_PATTERN_EN with tp_sel=1, RGB_WIDTH=3 → rgb = 0..7 across eight 100-pixel bars; with macro undefined, rgb tracks pixel_data.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: DVI/HDMI timing generator with frame-boundary reconfig, pixel-fetch latency pipeline and line/frame strobes; optional colour bars under VTG_TEST_PATTERN_EN
module video_timing_gen #(
   parameter int   RGB_WIDTH     = 3,
   parameter int   COORD_WIDTH   = 11,
   parameter int   PIXEL_LATENCY = 1,
   parameter int   H_ACTIVE      = 800,
   parameter int   H_FP          = 56,
   parameter int   H_SYNC        = 120,
   parameter int   H_BP          = 64,
   parameter int   V_ACTIVE      = 600,
   parameter int   V_FP          = 37,
   parameter int   V_SYNC        = 6,
   parameter int   V_BP          = 23,
   parameter logic H_POL         = 1'b1,
   parameter logic V_POL         = 1'b1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [11:0]            cfg_h_active,
   input  logic [11:0]            cfg_h_fp,
   input  logic [11:0]            cfg_h_sync,
   input  logic [11:0]            cfg_h_bp,
   input  logic [11:0]            cfg_v_active,
   input  logic [11:0]            cfg_v_fp,
   input  logic [11:0]            cfg_v_sync,
   input  logic [11:0]            cfg_v_bp,
   input  logic                   cfg_valid,
   output logic                   cfg_pending,
   output logic                   clk_out,
   output logic [COORD_WIDTH-1:0] x,
   output logic [COORD_WIDTH-1:0] y,
   output logic                   fetch,
   input  logic [RGB_WIDTH-1:0]   pixel_data,
   output logic                   line_start,
   output logic                   frame_start,
   output logic                   de,
   output logic                   hs,
   output logic                   vs,
   output logic [RGB_WIDTH-1:0]   rgb,
   input  logic                   tp_sel
);
   localparam int PW = PIXEL_LATENCY + 1;
   // timing sets packed as h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp (index 0..7)
   localparam logic [7:0][11:0] DEF = {12'(V_BP), 12'(V_SYNC), 12'(V_FP), 12'(V_ACTIVE),
                                       12'(H_BP), 12'(H_SYNC), 12'(H_FP), 12'(H_ACTIVE)};
   logic [7:0][11:0] act, pend;
   logic [11:0] hc, vc;
   logic [13:0] hc_w, vc_w, h_off, v_off, h_tot, v_tot;
   logic h_end, v_end, frame_end, hs_raw, vs_raw, de_l;
   logic [PW-1:0] de_sr, hs_sr, vs_sr;
   logic [RGB_WIDTH-1:0] pix;

   assign hc_w = {2'b0, hc};
   assign vc_w = {2'b0, vc};
   assign h_off = 14'(act[1]) + 14'(act[2]) + 14'(act[3]);
   assign v_off = 14'(act[5]) + 14'(act[6]) + 14'(act[7]);
   assign h_tot = h_off + 14'(act[0]);
   assign v_tot = v_off + 14'(act[4]);
   assign h_end = hc_w == h_tot - 14'd1;
   assign v_end = vc_w == v_tot - 14'd1;
   assign frame_end = h_end && v_end;
   assign fetch = hc_w >= h_off && vc_w >= v_off;
   assign x = fetch ? COORD_WIDTH'(hc_w - h_off) : '0;
   assign y = fetch ? COORD_WIDTH'(vc_w - v_off) : '0;
   assign hs_raw = (hc_w >= 14'(act[1]) && hc_w < 14'(act[1]) + 14'(act[2])) ? H_POL : ~H_POL;
   assign vs_raw = (vc_w >= 14'(act[5]) && vc_w < 14'(act[5]) + 14'(act[6])) ? V_POL : ~V_POL;
   assign line_start = hc == '0;
   assign frame_start = hc == '0 && vc == '0;
   assign clk_out = clk_in;
   assign de = de_sr[PIXEL_LATENCY];
   assign hs = hs_sr[PIXEL_LATENCY];
   assign vs = vs_sr[PIXEL_LATENCY];

   // de tap aligned with pixel_data arriving for the x/y issued PIXEL_LATENCY cycles ago
   if (PIXEL_LATENCY == 0) begin : g_l0
      assign de_l = fetch;
   end else begin : g_ln
      assign de_l = de_sr[PIXEL_LATENCY-1];
   end

`ifdef VTG_TEST_PATTERN_EN
   logic [2:0] bar, bar_l;
   assign bar = 3'((32'(x) * 8) / H_ACTIVE);
   if (PIXEL_LATENCY == 0) begin : g_b0
      assign bar_l = bar;
   end else begin : g_bn
      logic [PIXEL_LATENCY-1:0][2:0] bar_sr;
      // carry the bar index alongside de so the pattern keeps pixel_data's alignment
      always_ff @(posedge clk_in) begin
         bar_sr <= (3*PIXEL_LATENCY)'({bar_sr, bar});
      end
      assign bar_l = bar_sr[PIXEL_LATENCY-1];
   end
   assign pix = tp_sel ? RGB_WIDTH'({RGB_WIDTH{bar_l}}) : pixel_data;
`else
   logic unused_tp_sel;
   assign unused_tp_sel = tp_sel;
   assign pix = pixel_data;
`endif

   // raster counters and double-buffered timing; pending set swaps in only on the frame wrap
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hc <= '0;
         vc <= '0;
         act <= DEF;
         pend <= DEF;
         cfg_pending <= 1'b0;
      end else begin
         hc <= h_end ? '0 : hc + 12'd1;
         if (h_end) vc <= v_end ? '0 : vc + 12'd1;
         if (frame_end) act <= pend;
         if (cfg_valid) pend <= {cfg_v_bp, cfg_v_sync, cfg_v_fp, cfg_v_active,
                                 cfg_h_bp, cfg_h_sync, cfg_h_fp, cfg_h_active};
         if (cfg_valid || frame_end) cfg_pending <= cfg_valid;
      end
   end

   // delay controls by PIXEL_LATENCY+1 and register the pixel so rgb lands with de/hs/vs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         de_sr <= '0;
         hs_sr <= {PW{~H_POL}};
         vs_sr <= {PW{~V_POL}};
         rgb <= '0;
      end else begin
         de_sr <= PW'({de_sr, fetch});
         hs_sr <= PW'({hs_sr, hs_raw});
         vs_sr <= PW'({vs_sr, vs_raw});
         rgb <= de_l ? pix : '0;
      end
   end
endmodule
